// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel line-buffer writer.
package sobel_pkg;

    typedef enum logic [1:0] {IDLE, WRITE, READ, FLUSH} wr_state_t;

    // rd_ram encodings, named by which RAM holds the newest line
    localparam logic [1:0] RD_RAM_NEW0 = 2'b10;
    localparam logic [1:0] RD_RAM_NEW1 = 2'b00;
    localparam logic [1:0] RD_RAM_NEW2 = 2'b01;

    localparam int DATA_WD_DFLT = 8;

    function automatic logic [1:0] rd_ram_of(input logic [2:0] newest);
        case (newest)
            3'b001:  return RD_RAM_NEW0;
            3'b010:  return RD_RAM_NEW1;
            3'b100:  return RD_RAM_NEW2;
            default: return RD_RAM_NEW1;
        endcase
    endfunction

endpackage

// File: rtl/line_buffer_write_ctrl_if.sv
// Pixel stream in, line-RAM write port and window-mux read selects out.
interface line_buffer_write_ctrl_if #(
    parameter int DATA_WD = 8,
    parameter int ADDR_WD = 10,
    parameter int ROW_WD  = 9
);
    logic               sof;
    logic               in_valid;
    logic [DATA_WD-1:0] in_data;
    logic               in_ready;
    logic [2:0]         wr_en;
    logic [ADDR_WD-1:0] wr_addr;
    logic [DATA_WD-1:0] wr_data;
    logic [ADDR_WD-1:0] rd_addr;
    logic [1:0]         rd_ram;
    logic               first_line;
    logic               last_line;
    logic               win_valid;
    logic [ADDR_WD-1:0] win_col;
    logic [ROW_WD-1:0]  win_row;
    logic               frame_done;

    modport master (
        output sof, in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data, rd_addr, rd_ram,
               first_line, last_line, win_valid, win_col, win_row, frame_done
    );

    modport slave (
        input  sof, in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data, rd_addr, rd_ram,
               first_line, last_line, win_valid, win_col, win_row, frame_done
    );
endinterface

// File: rtl/line_buffer_write_ctrl.sv
// Writes a raster stream into three rotating line RAMs and runs one read sweep
// per landed line, producing the window-mux selects for the Sobel core.
module line_buffer_write_ctrl
    import sobel_pkg::*;
#(
    parameter int DATA_WD = DATA_WD_DFLT,
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int ADDR_WD = $clog2(WIDTH),
    parameter int ROW_WD  = $clog2(HEIGHT)
) (
    input  logic clk,
    input  logic rst,
    line_buffer_write_ctrl_if.slave bus
);

    if (WIDTH < 2 || HEIGHT < 3 || (HEIGHT % 3) != 0) begin : g_param_check
        $error("line_buffer_write_ctrl: need WIDTH >= 2, HEIGHT >= 3, HEIGHT %% 3 == 0");
    end

    localparam logic [ADDR_WD-1:0] LAST_COL = ADDR_WD'(WIDTH - 1);
    localparam logic [ROW_WD-1:0]  LAST_ROW = ROW_WD'(HEIGHT - 1);

    wr_state_t          state;
    logic [ADDR_WD-1:0] col;
    logic [ROW_WD-1:0]  line;      // line currently being written (L)
    logic [2:0]         line_sel;  // one-hot RAM holding line L
    logic               accept;
    logic               sweep;
    logic [ROW_WD-1:0]  centre;

    assign accept = bus.in_valid & bus.in_ready;
    assign sweep  = (state == READ) || (state == FLUSH);
    assign centre = (state == FLUSH) ? LAST_ROW : line - ROW_WD'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            col            <= '0;
            line           <= '0;
            line_sel       <= 3'b001;
            bus.in_ready   <= 1'b1;
            bus.wr_en      <= '0;
            bus.wr_addr    <= '0;
            bus.wr_data    <= '0;
            bus.rd_addr    <= '0;
            bus.rd_ram     <= RD_RAM_NEW1;
            bus.first_line <= 1'b0;
            bus.last_line  <= 1'b0;
            bus.win_valid  <= 1'b0;
            bus.win_col    <= '0;
            bus.win_row    <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.wr_en      <= '0;
            bus.win_valid  <= sweep;
            bus.win_col    <= bus.rd_addr;
            bus.frame_done <= (state == FLUSH) && (bus.rd_addr == LAST_COL);

            // Selects are registered alongside win_valid so they line up with RAM data
            if (sweep) begin
                bus.win_row    <= centre;
                bus.first_line <= (centre == '0);
                bus.last_line  <= (state == FLUSH);
                if (state == READ && centre != '0)
                    bus.rd_ram <= rd_ram_of(line_sel);
            end else begin
                bus.first_line <= 1'b0;
                bus.last_line  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept && bus.sof) begin
                        bus.wr_en   <= 3'b001;
                        bus.wr_addr <= '0;
                        bus.wr_data <= bus.in_data;
                        col         <= ADDR_WD'(1);
                        line        <= '0;
                        line_sel    <= 3'b001;
                        state       <= WRITE;
                    end
                end
                WRITE: begin
                    if (accept) begin
                        bus.wr_data <= bus.in_data;
                        if (bus.sof) begin
                            bus.wr_en   <= 3'b001;
                            bus.wr_addr <= '0;
                            col         <= ADDR_WD'(1);
                            line        <= '0;
                            line_sel    <= 3'b001;
                        end else begin
                            bus.wr_en   <= line_sel;
                            bus.wr_addr <= col;
                            if (col == LAST_COL) begin
                                col <= '0;
                                if (line == '0) begin
                                    line     <= ROW_WD'(1);
                                    line_sel <= {line_sel[1:0], line_sel[2]};
                                end else begin
                                    state        <= READ;
                                    bus.in_ready <= 1'b0;
                                    bus.rd_addr  <= '0;
                                end
                            end else begin
                                col <= col + ADDR_WD'(1);
                            end
                        end
                    end
                end
                READ: begin
                    if (bus.rd_addr == LAST_COL) begin
                        bus.rd_addr <= '0;
                        if (line == LAST_ROW) begin
                            state <= FLUSH;
                        end else begin
                            state        <= WRITE;
                            bus.in_ready <= 1'b1;
                            line         <= line + ROW_WD'(1);
                            line_sel     <= {line_sel[1:0], line_sel[2]};
                        end
                    end else begin
                        bus.rd_addr <= bus.rd_addr + ADDR_WD'(1);
                    end
                end
                FLUSH: begin
                    if (bus.rd_addr == LAST_COL) begin
                        bus.rd_addr  <= '0;
                        bus.in_ready <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        bus.rd_addr <= bus.rd_addr + ADDR_WD'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_buffer_write_ctrl.sv
// Directed bench for line_buffer_write_ctrl with WIDTH=4, HEIGHT=6, data = row*16+col.
module tb_line_buffer_write_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    line_buffer_write_ctrl_if #(.DATA_WD(8), .ADDR_WD(2), .ROW_WD(3)) bus ();

    line_buffer_write_ctrl #(.DATA_WD(8), .WIDTH(4), .HEIGHT(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Observation logs filled on the falling edge
    logic [12:0] wr_log [$];   // {wr_en, wr_addr, wr_data}
    logic [7:0]  win_log [$];  // {row, col, first, last, frame_done}
    logic [1:0]  ram_log [$];
    logic [1:0]  rd_log [$];
    int          run_log [$];
    int          low_run = 0;
    int          fd_cnt  = 0;
    int          lag_err = 0;
    logic        prev_low = 1'b0;
    logic [1:0]  prev_addr = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.wr_en != 3'b000) wr_log.push_back({bus.wr_en, bus.wr_addr, bus.wr_data});
            if (bus.win_valid) begin
                win_log.push_back({bus.win_row, bus.win_col, bus.first_line, bus.last_line, bus.frame_done});
                ram_log.push_back(bus.rd_ram);
            end
            if (bus.frame_done) fd_cnt++;
            if (!bus.in_ready) begin
                low_run++;
                rd_log.push_back(bus.rd_addr);
            end else if (low_run != 0) begin
                run_log.push_back(low_run);
                low_run = 0;
            end
            if (bus.win_valid !== prev_low || (prev_low && bus.win_col !== prev_addr)) lag_err++;
            prev_low  = !bus.in_ready;
            prev_addr = bus.rd_addr;
        end
    end

    task automatic clear_logs();
        wr_log.delete(); win_log.delete(); ram_log.delete(); rd_log.delete(); run_log.delete();
        low_run = 0; fd_cnt = 0; lag_err = 0;
    endtask

    task automatic send_beat(input logic s, input logic [7:0] d, input int gap_pct);
        int t;
        logic rdy;
        while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.sof = s; bus.in_data = d; bus.in_valid = 1'b1;
        t = 0;
        forever begin
            rdy = bus.in_ready;
            @(posedge clk); #1;
            if (rdy) break;
            t++;
            if (t > 100) begin
                n_checks++; n_fail++;
                $display("FAIL beat_accept: in_ready stuck at %0b, required 1 within 100 cycles", bus.in_ready);
                break;
            end
        end
        bus.in_valid = 1'b0; bus.sof = 1'b0;
    endtask

    task automatic send_pixels(input int beats, input int gap_pct);
        for (int i = 0; i < beats; i++)
            send_beat(i == 0, 8'((i / 4) * 16 + (i % 4)), gap_pct);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.sof = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.rd_addr, bus.rd_ram, bus.first_line,
             bus.last_line, bus.win_valid, bus.win_col, bus.win_row, bus.frame_done} !== {1'b1, 26'd0}) begin
            n_fail++;
            $display("FAIL reset_outputs: in_ready=%0b wr_en=%b win_valid=%0b rd_ram=%b, required in_ready=1 rest 0",
                     bus.in_ready, bus.wr_en, bus.win_valid, bus.rd_ram);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_full_frame();
        logic [12:0] ew;
        logic [7:0]  ev;
        clear_logs();
        send_pixels(24, 0);
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (wr_log.size() !== 24) begin
            n_fail++; $display("FAIL full_wr_count: got %0d, required 24", wr_log.size());
        end
        for (int i = 0; i < 24 && i < wr_log.size(); i++) begin
            ew = {3'(1 << ((i / 4) % 3)), 2'(i % 4), 8'((i / 4) * 16 + (i % 4))};
            n_checks++;
            if (wr_log[i] !== ew) begin
                n_fail++; $display("FAIL full_wr[%0d]: got %h, required %h", i, wr_log[i], ew);
            end
        end
        n_checks++;
        if (win_log.size() !== 24) begin
            n_fail++; $display("FAIL full_win_count: got %0d, required 24", win_log.size());
        end
        for (int k = 0; k < 24 && k < win_log.size(); k++) begin
            ev = {3'(k / 4), 2'(k % 4), (k / 4) == 0, (k / 4) == 5, k == 23};
            n_checks++;
            if (win_log[k] !== ev) begin
                n_fail++; $display("FAIL full_win[%0d]: got %b, required %b", k, win_log[k], ev);
            end
        end
        n_checks++;
        if (fd_cnt !== 1) begin
            n_fail++; $display("FAIL full_frame_done: got %0d pulses, required 1", fd_cnt);
        end
    endtask

    task automatic test_rd_ram();
        logic [1:0] exp_ram [4] = '{2'b01, 2'b10, 2'b00, 2'b01};
        int         exp_run [5] = '{4, 4, 4, 4, 8};
        clear_logs();
        send_pixels(24, 0);
        repeat (20) @(posedge clk);
        #1;
        for (int r = 1; r <= 4; r++) begin
            n_checks++;
            if (ram_log.size() < 24 || ram_log[r * 4] !== exp_ram[r - 1]) begin
                n_fail++; $display("FAIL rd_ram_row%0d: got %b, required %b", r,
                                   (ram_log.size() > r * 4) ? ram_log[r * 4] : 2'bxx, exp_ram[r - 1]);
            end
        end
        n_checks++;
        if (run_log.size() !== 5) begin
            n_fail++; $display("FAIL ready_low_runs: got %0d runs, required 5", run_log.size());
        end
        for (int j = 0; j < 5 && j < run_log.size(); j++) begin
            n_checks++;
            if (run_log[j] !== exp_run[j]) begin
                n_fail++; $display("FAIL ready_low_len[%0d]: got %0d, required %0d", j, run_log[j], exp_run[j]);
            end
        end
        n_checks++;
        if (rd_log.size() !== 24) begin
            n_fail++; $display("FAIL rd_addr_count: got %0d, required 24", rd_log.size());
        end
        for (int j = 0; j < 24 && j < rd_log.size(); j++) begin
            n_checks++;
            if (rd_log[j] !== 2'(j % 4)) begin
                n_fail++; $display("FAIL rd_addr[%0d]: got %0d, required %0d", j, rd_log[j], j % 4);
            end
        end
        n_checks++;
        if (lag_err !== 0) begin
            n_fail++; $display("FAIL win_lag: %0d cycles off, required 0", lag_err);
        end
    endtask

    task automatic test_gaps();
        logic [12:0] ew;
        logic [7:0]  ev;
        clear_logs();
        send_pixels(24, 50);
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (wr_log.size() !== 24 || win_log.size() !== 24) begin
            n_fail++; $display("FAIL gap_counts: writes %0d windows %0d, required 24 and 24", wr_log.size(), win_log.size());
        end
        for (int i = 0; i < 24 && i < wr_log.size(); i++) begin
            ew = {3'(1 << ((i / 4) % 3)), 2'(i % 4), 8'((i / 4) * 16 + (i % 4))};
            n_checks++;
            if (wr_log[i] !== ew) begin
                n_fail++; $display("FAIL gap_wr[%0d]: got %h, required %h", i, wr_log[i], ew);
            end
        end
        for (int k = 0; k < 24 && k < win_log.size(); k++) begin
            ev = {3'(k / 4), 2'(k % 4), (k / 4) == 0, (k / 4) == 5, k == 23};
            n_checks++;
            if (win_log[k] !== ev) begin
                n_fail++; $display("FAIL gap_win[%0d]: got %b, required %b", k, win_log[k], ev);
            end
        end
    endtask

    task automatic test_idle_drop();
        clear_logs();
        for (int i = 0; i < 3; i++) send_beat(1'b0, 8'h55, 0);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (wr_log.size() !== 0) begin
            n_fail++; $display("FAIL idle_drop: got %0d writes, required 0", wr_log.size());
        end
        send_beat(1'b1, 8'hAB, 0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (wr_log.size() !== 1 || wr_log[0] !== {3'b001, 2'd0, 8'hAB}) begin
            n_fail++; $display("FAIL idle_sof_write: got %0d writes first %h, required 1 write %h",
                               wr_log.size(), (wr_log.size() > 0) ? wr_log[0] : 13'h0, {3'b001, 2'd0, 8'hAB});
        end
    endtask

    task automatic test_sof_abort();
        clear_logs();
        send_pixels(10, 0);
        send_pixels(24, 0);
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (wr_log.size() !== 34 || wr_log[9] !== {3'b100, 2'd1, 8'h21} || wr_log[10] !== {3'b001, 2'd0, 8'h00}) begin
            n_fail++; $display("FAIL abort_writes: got %0d writes, [9]=%h [10]=%h, required 34, %h, %h", wr_log.size(),
                               (wr_log.size() > 10) ? wr_log[9] : 13'h0, (wr_log.size() > 10) ? wr_log[10] : 13'h0,
                               {3'b100, 2'd1, 8'h21}, {3'b001, 2'd0, 8'h00});
        end
        n_checks++;
        if (win_log.size() !== 28) begin
            n_fail++; $display("FAIL abort_win_count: got %0d, required 28", win_log.size());
        end
        for (int k = 4; k < 28 && k < win_log.size(); k++) begin
            n_checks++;
            if (win_log[k][7:5] !== 3'((k - 4) / 4)) begin
                n_fail++; $display("FAIL abort_win_row[%0d]: got %0d, required %0d", k, win_log[k][7:5], (k - 4) / 4);
            end
        end
        n_checks++;
        if (fd_cnt !== 1) begin
            n_fail++; $display("FAIL abort_frame_done: got %0d pulses, required 1", fd_cnt);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int t;
        logic [7:0] ev;
        clear_logs();
        send_pixels(20, 0);
        t = 0;
        @(negedge clk);
        while (!(bus.win_valid && bus.win_row == 3'd3) && t < 20) begin
            @(negedge clk); t++;
        end
        n_checks++;
        if (t >= 20) begin
            n_fail++; $display("FAIL rst_sweep_wait: row-3 window not seen, win_row=%0d required 3", bus.win_row);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.rd_addr, bus.rd_ram, bus.first_line,
             bus.last_line, bus.win_valid, bus.win_col, bus.win_row, bus.frame_done} !== {1'b1, 26'd0}) begin
            n_fail++; $display("FAIL rst_mid_outputs: in_ready=%0b win_valid=%0b win_row=%0d rd_addr=%0d, required 1,0,0,0",
                               bus.in_ready, bus.win_valid, bus.win_row, bus.rd_addr);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.win_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_after: win_valid=%0b in_ready=%0b, required 0 and 1", bus.win_valid, bus.in_ready);
        end
        #1;
        clear_logs();
        send_pixels(24, 0);
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (wr_log.size() !== 24 || win_log.size() !== 24 || fd_cnt !== 1) begin
            n_fail++; $display("FAIL rst_refill_counts: writes %0d windows %0d frame_done %0d, required 24 24 1",
                               wr_log.size(), win_log.size(), fd_cnt);
        end
        for (int k = 0; k < 24 && k < win_log.size(); k++) begin
            ev = {3'(k / 4), 2'(k % 4), (k / 4) == 0, (k / 4) == 5, k == 23};
            n_checks++;
            if (win_log[k] !== ev) begin
                n_fail++; $display("FAIL rst_refill_win[%0d]: got %b, required %b", k, win_log[k], ev);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_rd_ram();
        test_gaps();
        test_idle_drop();
        test_sof_abort();
        test_reset_mid_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
